// File: rtl/qft_cphase_stage.sv
`default_nettype none
// ============================================================================
//  Module   : qft_cphase_stage
//  Purpose  : Controlled-phase stage of the pipelined QFT datapath. Amplitudes
//             whose index has both CTL and TGT bits set get a complex
//             rotation; all others ride a delay-matched pass-through.
//  Revision : 1.0  initial release
// ============================================================================
module qft_cphase_stage #(
    parameter int NQ    = 3,
    parameter int WIDTH = 8,
    parameter int FRAC  = 4,
    parameter int TGT   = 2,
    parameter int CTL   = 1,
    parameter int LAT   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [(2**NQ)*WIDTH-1:0]    in_re,
    input  logic [(2**NQ)*WIDTH-1:0]    in_im,
    input  logic [WIDTH-1:0]            rot_re,
    input  logic [WIDTH-1:0]            rot_im,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [(2**NQ)*WIDTH-1:0]    out_re,
    output logic [(2**NQ)*WIDTH-1:0]    out_im,
    output logic                        out_sat
);

    localparam int c_na = 2**NQ;
    localparam int c_vw = c_na * WIDTH;
    localparam int c_fw = 2 * WIDTH + 1;

    localparam logic signed [2*WIDTH+1:0] c_half =
        {{(2*WIDTH+1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [2*WIDTH+1:0] c_max =
        {{(WIDTH+3){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH+1:0] c_min =
        {{(WIDTH+3){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_max_w = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_min_w = {1'b1, {(WIDTH-1){1'b0}}};

    if (CTL == TGT || CTL < 0 || CTL >= NQ || TGT < 0 || TGT >= NQ ||
        LAT < 1 || FRAC < 1 || FRAC >= WIDTH) begin : g_param_check
        $error("qft_cphase_stage: illegal parameter combination");
    end

    // Round half-up then saturate; MSB of the result flags saturation.
    function automatic logic [WIDTH:0] f_rnd_sat(input logic [c_fw-1:0] x);
        logic signed [2*WIDTH+1:0] t;
        t = $signed({x[c_fw-1], x}) + c_half;
        t = t >>> FRAC;
        if (t > c_max)
            f_rnd_sat = {1'b1, c_max_w};
        else if (t < c_min)
            f_rnd_sat = {1'b1, c_min_w};
        else
            f_rnd_sat = {1'b0, t[WIDTH-1:0]};
    endfunction

    logic               w_en;
    logic [LAT-1:0]     r_valid;
    logic [c_vw-1:0]    w_s1_re;
    logic [c_vw-1:0]    w_s1_im;
    logic [c_na-1:0]    w_lane_sat;
    logic               w_s1_sat;
    logic               w_last_sat;

    assign out_valid = r_valid[LAT-1];
    assign w_en      = !out_valid || out_ready;
    assign in_ready  = w_en && rst_n;
    assign w_s1_sat  = |w_lane_sat;
    assign out_sat   = w_last_sat && out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_en) begin
            r_valid[0] <= in_valid;
            for (int i = 1; i < LAT; i++)
                r_valid[i] <= r_valid[i-1];
        end
    end

    // Stage 1: multiply at capture, keep full precision in the first register.
    for (genvar k = 0; k < c_na; k++) begin : g_lane
        if ((((k >> CTL) % 2) == 1) && (((k >> TGT) % 2) == 1)) begin : g_rot
            logic signed [2*WIDTH-1:0] w_ar;
            logic signed [2*WIDTH-1:0] w_ai;
            logic signed [2*WIDTH-1:0] w_cr;
            logic signed [2*WIDTH-1:0] w_ci;
            logic signed [2*WIDTH-1:0] w_p_rr;
            logic signed [2*WIDTH-1:0] w_p_ii;
            logic signed [2*WIDTH-1:0] w_p_ri;
            logic signed [2*WIDTH-1:0] w_p_ir;
            logic [c_fw-1:0]           w_sum_re;
            logic [c_fw-1:0]           w_sum_im;
            logic [c_fw-1:0]           r_acc_re;
            logic [c_fw-1:0]           r_acc_im;
            logic [WIDTH:0]            w_rs_re;
            logic [WIDTH:0]            w_rs_im;

            assign w_ar = {{WIDTH{in_re[k*WIDTH+WIDTH-1]}}, in_re[k*WIDTH +: WIDTH]};
            assign w_ai = {{WIDTH{in_im[k*WIDTH+WIDTH-1]}}, in_im[k*WIDTH +: WIDTH]};
            assign w_cr = {{WIDTH{rot_re[WIDTH-1]}}, rot_re};
            assign w_ci = {{WIDTH{rot_im[WIDTH-1]}}, rot_im};

            assign w_p_rr = w_ar * w_cr;
            assign w_p_ii = w_ai * w_ci;
            assign w_p_ri = w_ar * w_ci;
            assign w_p_ir = w_ai * w_cr;

            assign w_sum_re = {w_p_rr[2*WIDTH-1], w_p_rr} - {w_p_ii[2*WIDTH-1], w_p_ii};
            assign w_sum_im = {w_p_ri[2*WIDTH-1], w_p_ri} + {w_p_ir[2*WIDTH-1], w_p_ir};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc_re <= '0;
                    r_acc_im <= '0;
                end else if (w_en) begin
                    r_acc_re <= w_sum_re;
                    r_acc_im <= w_sum_im;
                end
            end

            assign w_rs_re = f_rnd_sat(r_acc_re);
            assign w_rs_im = f_rnd_sat(r_acc_im);
            assign w_s1_re[k*WIDTH +: WIDTH] = w_rs_re[WIDTH-1:0];
            assign w_s1_im[k*WIDTH +: WIDTH] = w_rs_im[WIDTH-1:0];
            assign w_lane_sat[k]             = w_rs_re[WIDTH] | w_rs_im[WIDTH];
        end else begin : g_pass
            logic [WIDTH-1:0] r_d_re;
            logic [WIDTH-1:0] r_d_im;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d_re <= '0;
                    r_d_im <= '0;
                end else if (w_en) begin
                    r_d_re <= in_re[k*WIDTH +: WIDTH];
                    r_d_im <= in_im[k*WIDTH +: WIDTH];
                end
            end

            assign w_s1_re[k*WIDTH +: WIDTH] = r_d_re;
            assign w_s1_im[k*WIDTH +: WIDTH] = r_d_im;
            assign w_lane_sat[k]             = 1'b0;
        end
    end

    // Stages 2..LAT carry the rounded vector and its saturation flag.
    if (LAT > 1) begin : g_deep
        logic [c_vw-1:0] r_re_pipe  [1:LAT-1];
        logic [c_vw-1:0] r_im_pipe  [1:LAT-1];
        logic            r_sat_pipe [1:LAT-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 1; i < LAT; i++) begin
                    r_re_pipe[i]  <= '0;
                    r_im_pipe[i]  <= '0;
                    r_sat_pipe[i] <= 1'b0;
                end
            end else if (w_en) begin
                r_re_pipe[1]  <= w_s1_re;
                r_im_pipe[1]  <= w_s1_im;
                r_sat_pipe[1] <= w_s1_sat;
                for (int i = 2; i < LAT; i++) begin
                    r_re_pipe[i]  <= r_re_pipe[i-1];
                    r_im_pipe[i]  <= r_im_pipe[i-1];
                    r_sat_pipe[i] <= r_sat_pipe[i-1];
                end
            end
        end

        assign out_re     = r_re_pipe[LAT-1];
        assign out_im     = r_im_pipe[LAT-1];
        assign w_last_sat = r_sat_pipe[LAT-1];
    end else begin : g_shallow
        assign out_re     = w_s1_re;
        assign out_im     = w_s1_im;
        assign w_last_sat = w_s1_sat;
    end

endmodule
`default_nettype wire

// File: tb/tb_qft_cphase_stage.sv
`default_nettype none
// Testbench for qft_cphase_stage: directed and randomized vectors checked
// against a queue-based reference model of the stage.
module tb_qft_cphase_stage;

    localparam int NQ    = 3;
    localparam int WIDTH = 8;
    localparam int FRAC  = 4;
    localparam int TGT   = 2;
    localparam int CTL   = 1;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_re;
    logic [63:0] in_im;
    logic [7:0]  rot_re;
    logic [7:0]  rot_im;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_re;
    logic [63:0] out_im;
    logic        out_sat;

    qft_cphase_stage #(
        .NQ(NQ), .WIDTH(WIDTH), .FRAC(FRAC), .TGT(TGT), .CTL(CTL), .LAT(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .rot_re    (rot_re),
        .rot_im    (rot_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int          n_err = 0;
    int          n_chk = 0;
    logic [63:0] q_re [$];
    logic [63:0] q_im [$];
    logic        q_sat [$];
    int          q_age [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int rnd_sat(input int x, inout logic s);
        int r;
        r = (x + (1 << (FRAC - 1))) >>> FRAC;
        if (r > 127) begin
            r = 127;
            s = 1'b1;
        end else if (r < -128) begin
            r = -128;
            s = 1'b1;
        end
        return r;
    endfunction

    task automatic model_vec(input logic [63:0] re, input logic [63:0] im,
                             input logic [7:0] cr, input logic [7:0] ci,
                             output logic [63:0] ore, output logic [63:0] oim,
                             output logic s);
        int ar, ai, c, d, pr, pim;
        ore = re;
        oim = im;
        s   = 1'b0;
        c   = $signed(cr);
        d   = $signed(ci);
        for (int k = 0; k < 8; k++) begin
            if (((k >> CTL) % 2 == 1) && ((k >> TGT) % 2 == 1)) begin
                ar  = $signed(re[k*8 +: 8]);
                ai  = $signed(im[k*8 +: 8]);
                pr  = rnd_sat(ar * c - ai * d, s);
                pim = rnd_sat(ar * d + ai * c, s);
                ore[k*8 +: 8] = pr[7:0];
                oim[k*8 +: 8] = pim[7:0];
            end
        end
    endtask

    // One clock cycle: drive, check against model, advance the model.
    task automatic step(input logic v, input logic [63:0] re, input logic [63:0] im,
                        input logic [7:0] cr, input logic [7:0] ci,
                        input logic ordy, output logic acc);
        logic        m_ov, m_en, s;
        logic [63:0] ore, oim;
        @(negedge clk);
        in_valid  = v;
        in_re     = re;
        in_im     = im;
        rot_re    = cr;
        rot_im    = ci;
        out_ready = ordy;
        #1;
        m_ov = (q_age.size() > 0) && (q_age[0] == LAT);
        m_en = !m_ov || ordy;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        chk("in_ready", {63'd0, in_ready}, {63'd0, m_en});
        if (m_ov) begin
            chk("out_re", out_re, q_re[0]);
            chk("out_im", out_im, q_im[0]);
            chk("out_sat", {63'd0, out_sat}, {63'd0, q_sat[0]});
        end
        acc = v && m_en;
        if (m_en) begin
            if (m_ov) begin
                void'(q_re.pop_front());
                void'(q_im.pop_front());
                void'(q_sat.pop_front());
                void'(q_age.pop_front());
            end
            foreach (q_age[i]) q_age[i] = q_age[i] + 1;
            if (acc) begin
                model_vec(re, im, cr, ci, ore, oim, s);
                q_re.push_back(ore);
                q_im.push_back(oim);
                q_sat.push_back(s);
                q_age.push_back(1);
            end
        end
    endtask

    function automatic logic [63:0] fill(input logic [7:0] a);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = a;
        return v;
    endfunction

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && q_age.size() > 0; i++)
            step(1'b0, 64'd0, 64'd0, 8'd0, 8'd0, 1'b1, acc);
        chk("drain_empty", 64'(q_age.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        acc, pend, v;
        logic [63:0] re, im, vre[6];
        logic [7:0]  cr, ci;
        int          idx, cyc;

        rst_n = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
        rot_re = '0; rot_im = '0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_re", out_re, 64'd0);
        chk("rst_out_im", out_im, 64'd0);
        chk("rst_out_sat", {63'd0, out_sat}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors from the test plan
        step(1'b1, fill(8'd16), fill(8'd0), 8'd0, 8'd16, 1'b1, acc);
        re = fill(8'd16); im = fill(8'd0);
        re[48 +: 8] = 8'd16; im[48 +: 8] = 8'd16; re[56 +: 8] = 8'hFD;
        step(1'b1, re, im, 8'd11, 8'd11, 1'b1, acc);
        re = '0; im = '0; re[56 +: 8] = 8'd127; im[56 +: 8] = 8'd127;
        step(1'b1, re, im, 8'd16, 8'd16, 1'b1, acc);
        step(1'b1, fill(8'd16), fill(8'd0), 8'd0, 8'd16, 1'b1, acc);
        re = '0; im = '0; re[48 +: 8] = 8'hFF;
        step(1'b1, re, im, 8'd8, 8'd0, 1'b1, acc);
        re[48 +: 8] = 8'hFD;
        step(1'b1, re, im, 8'd8, 8'd0, 1'b1, acc);
        re[48 +: 8] = 8'd1;
        step(1'b1, re, im, 8'd8, 8'd0, 1'b1, acc);
        drain();

        // Backpressure: six distinct vectors, downstream stalls mid-stream
        for (int i = 0; i < 6; i++) begin
            vre[i] = {$urandom, $urandom};
            vre[i][7:0] = 8'(i * 10 + 1);
        end
        idx = 0;
        for (cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            step(1'b1, vre[idx], fill(8'(idx)), 8'(idx + 3), 8'(13 - idx),
                 !(cyc >= 5 && cyc < 8), acc);
            if (acc) idx++;
        end
        chk("bp_all_sent", 64'(idx), 64'd6);
        drain();

        // Randomized traffic with random bubbles and stalls
        pend = 1'b0;
        re = '0; im = '0; cr = '0; ci = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                re = {$urandom, $urandom};
                im = {$urandom, $urandom};
                cr = 8'($urandom);
                ci = 8'($urandom);
                v  = ($urandom_range(3) != 0);
            end else begin
                v  = 1'b1;
            end
            step(v, re, im, cr, ci, ($urandom_range(2) != 0), acc);
            pend = v && !acc;
        end
        drain();

        // Reset with vectors in flight
        for (int i = 0; i < 3; i++)
            step(1'b1, {$urandom, $urandom}, {$urandom, $urandom},
                 8'($urandom), 8'($urandom), 1'b1, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_re", out_re, 64'd0);
        chk("midrst_out_im", out_im, 64'd0);
        chk("midrst_out_sat", {63'd0, out_sat}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        q_re.delete(); q_im.delete(); q_sat.delete(); q_age.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, fill(8'd16), fill(8'd0), 8'd0, 8'd16, 1'b1, acc);
        for (int i = 0; i < 6; i++)
            step(1'b0, 64'd0, 64'd0, 8'd0, 8'd0, 1'b1, acc);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
